// File: rtl/dest_ip_filter_table_ctrl_pkg.sv
// dest_ip_filter_table_ctrl_pkg: shared FSM encoding, clear value and width helper for the filter table controller
package dest_ip_filter_table_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        WR_WAIT,
        CLR_ISSUE,
        CLR_WAIT,
        CLR_DONE
    } state_t;

    localparam logic [31:0] CLEAR_IP = 32'h0;

    function automatic int log2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/dest_ip_filter_table_ctrl_if.sv
// dest_ip_filter_table_ctrl_if: register-side read/write port of the destination-IP filter table
interface dest_ip_filter_table_ctrl_if #(
    parameter int ADDR_W = 4
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rd_ip;
    logic              rd_ack;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_ip;
    logic              wr_ack;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_ip,
        input  rd_ip, rd_ack, wr_ack
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_ip,
        output rd_ip, rd_ack, wr_ack
    );
endinterface

// File: rtl/dest_ip_filter_table_ctrl_op_timeout_counter.sv
// dest_ip_filter_table_ctrl_op_timeout_counter: counts wait cycles of one table operation and flags a missing ack
module dest_ip_filter_table_ctrl_op_timeout_counter
    import dest_ip_filter_table_ctrl_pkg::*;
#(
    parameter int ACK_TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    input  logic run,
    output logic expired
);
    localparam int CW = log2(ACK_TIMEOUT + 1);

    logic [CW-1:0] cnt;

    // expiry fires on the ACK_TIMEOUT-th waiting cycle, so the sw ack lands ACK_TIMEOUT cycles after the table request
    assign expired = run && (cnt == CW'(ACK_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset || restart) cnt <= '0;
        else if (run && !expired) cnt <= cnt + CW'(1);
    end
endmodule

// File: rtl/dest_ip_filter_table_ctrl.sv
// dest_ip_filter_table_ctrl: shares the filter table port between software requests and a bulk-clear engine
module dest_ip_filter_table_ctrl
    import dest_ip_filter_table_ctrl_pkg::*;
#(
    parameter int LUT_DEPTH      = 16,
    parameter int LUT_DEPTH_BITS = log2(LUT_DEPTH),
    parameter int ACK_TIMEOUT    = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      sw_rd_req,
    input  logic [LUT_DEPTH_BITS-1:0] sw_rd_addr,
    output logic [31:0]               sw_rd_ip,
    output logic                      sw_rd_ack,
    input  logic                      sw_wr_req,
    input  logic [LUT_DEPTH_BITS-1:0] sw_wr_addr,
    input  logic [31:0]               sw_wr_ip,
    output logic                      sw_wr_ack,
    input  logic                      clear_start,
    output logic                      clear_busy,
    output logic                      clear_done,
    output logic                      timeout_err,
    input  logic                      err_clr,
    dest_ip_filter_table_ctrl_if.master tbl
);
    localparam logic [LUT_DEPTH_BITS-1:0] LAST = LUT_DEPTH_BITS'(LUT_DEPTH - 1);

    state_t                    state;
    logic                      rd_pending, wr_pending, clr_pending;
    logic [LUT_DEPTH_BITS-1:0] rd_addr_q, wr_addr_q, clr_cnt;
    logic [31:0]               wr_ip_q;
    logic                      restart, run, expired;
    logic                      rd_ok, rd_to, wr_ok, wr_to;

    assign restart = (state == IDLE) || (state == CLR_ISSUE);
    assign run     = (state == RD_WAIT) || (state == WR_WAIT) || (state == CLR_WAIT);
    assign rd_ok   = (state == RD_WAIT) && tbl.rd_ack;
    assign rd_to   = (state == RD_WAIT) && !tbl.rd_ack && expired;
    assign wr_ok   = ((state == WR_WAIT) || (state == CLR_WAIT)) && tbl.wr_ack;
    assign wr_to   = ((state == WR_WAIT) || (state == CLR_WAIT)) && !tbl.wr_ack && expired;

    dest_ip_filter_table_ctrl_op_timeout_counter #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) op_timeout_counter (
        .clk,
        .reset,
        .restart,
        .run,
        .expired
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rd_pending  <= 1'b0;
            wr_pending  <= 1'b0;
            clr_pending <= 1'b0;
            rd_addr_q   <= '0;
            wr_addr_q   <= '0;
            wr_ip_q     <= '0;
            clr_cnt     <= '0;
            sw_rd_ip    <= '0;
            sw_rd_ack   <= 1'b0;
            sw_wr_ack   <= 1'b0;
            clear_busy  <= 1'b0;
            clear_done  <= 1'b0;
            timeout_err <= 1'b0;
            tbl.rd_req  <= 1'b0;
            tbl.rd_addr <= '0;
            tbl.wr_req  <= 1'b0;
            tbl.wr_addr <= '0;
            tbl.wr_ip   <= '0;
        end else begin
            tbl.rd_req <= 1'b0;
            tbl.wr_req <= 1'b0;
            sw_rd_ack  <= 1'b0;
            sw_wr_ack  <= 1'b0;
            clear_done <= 1'b0;
            if (!rd_pending && sw_rd_req) begin
                rd_pending <= 1'b1;
                rd_addr_q  <= sw_rd_addr;
            end
            if (!wr_pending && sw_wr_req) begin
                wr_pending <= 1'b1;
                wr_addr_q  <= sw_wr_addr;
                wr_ip_q    <= sw_wr_ip;
            end
            if (!clr_pending && !clear_busy && clear_start) clr_pending <= 1'b1;
            if (rd_to || wr_to) timeout_err <= 1'b1;
            else if (err_clr) timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_pending) begin
                        clr_pending <= 1'b0;
                        clear_busy  <= 1'b1;
                        clr_cnt     <= '0;
                        state       <= CLR_ISSUE;
                    end else if (wr_pending) begin
                        tbl.wr_req  <= 1'b1;
                        tbl.wr_addr <= wr_addr_q;
                        tbl.wr_ip   <= wr_ip_q;
                        state       <= WR_WAIT;
                    end else if (rd_pending) begin
                        tbl.rd_req  <= 1'b1;
                        tbl.rd_addr <= rd_addr_q;
                        state       <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (rd_ok || rd_to) begin
                        sw_rd_ip   <= rd_ok ? tbl.rd_ip : 32'h0;
                        sw_rd_ack  <= 1'b1;
                        rd_pending <= 1'b0;
                        state      <= IDLE;
                    end
                end
                WR_WAIT: begin
                    if (wr_ok || wr_to) begin
                        sw_wr_ack  <= 1'b1;
                        wr_pending <= 1'b0;
                        state      <= IDLE;
                    end
                end
                CLR_ISSUE: begin
                    tbl.wr_req  <= 1'b1;
                    tbl.wr_addr <= clr_cnt;
                    tbl.wr_ip   <= CLEAR_IP;
                    state       <= CLR_WAIT;
                end
                CLR_WAIT: begin
                    if (wr_ok || wr_to) begin
                        if (clr_cnt == LAST) state <= CLR_DONE;
                        else begin
                            clr_cnt <= clr_cnt + LUT_DEPTH_BITS'(1);
                            state   <= CLR_ISSUE;
                        end
                    end
                end
                CLR_DONE: begin
                    clear_done <= 1'b1;
                    clear_busy <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dest_ip_filter_table_ctrl.sv
// tb_dest_ip_filter_table_ctrl: directed scenarios against a behavioural filter table with programmable ack delay
module tb_dest_ip_filter_table_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sw_rd_req = 1'b0;
    logic [3:0]  sw_rd_addr = '0;
    logic [31:0] sw_rd_ip;
    logic        sw_rd_ack;
    logic        sw_wr_req = 1'b0;
    logic [3:0]  sw_wr_addr = '0;
    logic [31:0] sw_wr_ip = '0;
    logic        sw_wr_ack;
    logic        clear_start = 1'b0;
    logic        clear_busy, clear_done, timeout_err;
    logic        err_clr = 1'b0;

    int total = 0;
    int bad = 0;
    int rd_dly = 0;
    int wr_dly = 0;
    bit rd_en = 1'b1;
    bit wr_en = 1'b1;
    int rd_tmr, wr_tmr;
    logic [31:0] mem [16];

    dest_ip_filter_table_ctrl_if #(.ADDR_W(4)) tbl ();

    dest_ip_filter_table_ctrl #(
        .LUT_DEPTH(16),
        .ACK_TIMEOUT(64)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sw_rd_req(sw_rd_req),
        .sw_rd_addr(sw_rd_addr),
        .sw_rd_ip(sw_rd_ip),
        .sw_rd_ack(sw_rd_ack),
        .sw_wr_req(sw_wr_req),
        .sw_wr_addr(sw_wr_addr),
        .sw_wr_ip(sw_wr_ip),
        .sw_wr_ack(sw_wr_ack),
        .clear_start(clear_start),
        .clear_busy(clear_busy),
        .clear_done(clear_done),
        .timeout_err(timeout_err),
        .err_clr(err_clr),
        .tbl(tbl)
    );

    always #5 clk = ~clk;

    // table model: ack appears dly+1 cycles after the request; entries reset to A000_000i
    always @(posedge clk) begin
        if (reset) begin
            rd_tmr     <= 0;
            wr_tmr     <= 0;
            tbl.rd_ack <= 1'b0;
            tbl.wr_ack <= 1'b0;
            tbl.rd_ip  <= '0;
            for (int i = 0; i < 16; i++) mem[i] <= 32'hA000_0000 | 32'(i);
        end else begin
            rd_tmr     <= tbl.rd_req ? rd_dly : (rd_tmr > 0 ? rd_tmr - 1 : 0);
            wr_tmr     <= tbl.wr_req ? wr_dly : (wr_tmr > 0 ? wr_tmr - 1 : 0);
            tbl.rd_ack <= rd_en && ((tbl.rd_req && rd_dly == 0) || (!tbl.rd_req && rd_tmr == 1));
            tbl.wr_ack <= wr_en && ((tbl.wr_req && wr_dly == 0) || (!tbl.wr_req && wr_tmr == 1));
            tbl.rd_ip  <= mem[tbl.rd_addr];
            if (tbl.wr_req) mem[tbl.wr_addr] <= tbl.wr_ip;
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({sw_rd_ack, sw_wr_ack, clear_busy, clear_done, timeout_err, tbl.rd_req, tbl.wr_req} !== 7'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 0000000", {sw_rd_ack, sw_wr_ack, clear_busy, clear_done, timeout_err, tbl.rd_req, tbl.wr_req});
        end
        total++;
        if (sw_rd_ip !== 32'h0) begin bad++; $display("FAIL reset_rd_ip: got %h want 00000000", sw_rd_ip); end
        total++;
        if ({tbl.rd_addr, tbl.wr_addr, tbl.wr_ip} !== 40'h0) begin
            bad++;
            $display("FAIL reset_tbl_bus: got %h want 0", {tbl.rd_addr, tbl.wr_addr, tbl.wr_ip});
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_latency();
        logic [4:0] rq, ak;
        rd_dly = 0;
        sw_rd_req = 1'b1;
        sw_rd_addr = 4'd6;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            sw_rd_req = 1'b0;
            rq[i] = tbl.rd_req;
            ak[i] = sw_rd_ack;
        end
        total++;
        if (rq !== 5'b00010) begin bad++; $display("FAIL latency_tbl_rd_req: got %b want 00010", rq); end
        total++;
        if (ak !== 5'b01000) begin bad++; $display("FAIL latency_sw_rd_ack: got %b want 01000", ak); end
        total++;
        if (sw_rd_ip !== 32'hA000_0006) begin bad++; $display("FAIL latency_rd_ip: got %h want a0000006", sw_rd_ip); end
    endtask

    task automatic test_write_read();
        int n;
        logic [3:0] wa;
        logic [31:0] wi, got;
        wr_dly = 1;
        rd_dly = 1;
        sw_wr_req = 1'b1;
        sw_wr_addr = 4'd3;
        sw_wr_ip = 32'h0A00_0001;
        @(negedge clk);
        sw_wr_req = 1'b0;
        n = 0;
        wa = '0;
        wi = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tbl.wr_req) begin wa = tbl.wr_addr; wi = tbl.wr_ip; end
            n += int'(sw_wr_ack);
        end
        total++;
        if (n !== 1) begin bad++; $display("FAIL wr_ack_count: got %0d want 1", n); end
        total++;
        if ({wa, wi} !== {4'd3, 32'h0A00_0001}) begin bad++; $display("FAIL wr_tbl_bus: got %h/%h want 3/0a000001", wa, wi); end
        sw_rd_req = 1'b1;
        sw_rd_addr = 4'd3;
        @(negedge clk);
        sw_rd_req = 1'b0;
        n = 0;
        got = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sw_rd_ack) begin n++; got = sw_rd_ip; end
        end
        total++;
        if (n !== 1) begin bad++; $display("FAIL rd_ack_count: got %0d want 1", n); end
        total++;
        if (got !== 32'h0A00_0001) begin bad++; $display("FAIL rd_back_ip: got %h want 0a000001", got); end
    endtask

    task automatic test_same_cycle();
        int t_wr, t_rd, t_wack, nr, nw;
        logic [31:0] rip;
        logic ord;
        wr_dly = 1;
        rd_dly = 1;
        sw_rd_req = 1'b1;
        sw_rd_addr = 4'd5;
        sw_wr_req = 1'b1;
        sw_wr_addr = 4'd7;
        sw_wr_ip = 32'hC0A8_0107;
        t_wr = -1; t_rd = -1; t_wack = -1; nr = 0; nw = 0; rip = '0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            sw_rd_req = 1'b0;
            sw_wr_req = 1'b0;
            if (tbl.wr_req && t_wr < 0) t_wr = i;
            if (tbl.rd_req && t_rd < 0) t_rd = i;
            if (tbl.wr_ack && t_wack < 0) t_wack = i;
            if (sw_rd_ack) begin nr++; rip = sw_rd_ip; end
            nw += int'(sw_wr_ack);
        end
        ord = (t_wr >= 0) && (t_wack > t_wr) && (t_rd > t_wack);
        total++;
        if (ord !== 1'b1) begin bad++; $display("FAIL rw_order: got wr=%0d wack=%0d rd=%0d want wr<wack<rd", t_wr, t_wack, t_rd); end
        total++;
        if ({nr, nw} !== {32'd1, 32'd1}) begin bad++; $display("FAIL rw_ack_counts: got rd=%0d wr=%0d want 1/1", nr, nw); end
        total++;
        if (rip !== 32'hA000_0005) begin bad++; $display("FAIL rw_rd_ip: got %h want a0000005", rip); end
        total++;
        if (mem[7] !== 32'hC0A8_0107) begin bad++; $display("FAIL rw_mem7: got %h want c0a80107", mem[7]); end
    endtask

    task automatic test_dup_read();
        int nreq, nack;
        logic [3:0] ra;
        logic [31:0] rip;
        rd_dly = 3;
        sw_rd_req = 1'b1;
        sw_rd_addr = 4'd4;
        @(negedge clk);
        sw_rd_req = 1'b0;
        nreq = 0; nack = 0; ra = '0; rip = '0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            sw_rd_req = (i == 1);
            sw_rd_addr = (i == 1) ? 4'd9 : sw_rd_addr;
            if (tbl.rd_req) begin nreq++; ra = tbl.rd_addr; end
            if (sw_rd_ack) begin nack++; rip = sw_rd_ip; end
        end
        total++;
        if ({nreq, nack} !== {32'd1, 32'd1}) begin bad++; $display("FAIL dup_counts: got req=%0d ack=%0d want 1/1", nreq, nack); end
        total++;
        if (ra !== 4'd4) begin bad++; $display("FAIL dup_addr: got %0d want 4", ra); end
        total++;
        if (rip !== 32'hA000_0004) begin bad++; $display("FAIL dup_ip: got %h want a0000004", rip); end
    endtask

    task automatic test_timeout();
        int t_req, t_ack;
        logic [31:0] rip;
        logic te;
        rd_en = 1'b0;
        rd_dly = 0;
        sw_rd_req = 1'b1;
        sw_rd_addr = 4'd2;
        @(negedge clk);
        sw_rd_req = 1'b0;
        t_req = -1; t_ack = -1; rip = 32'hFFFF_FFFF; te = 1'b0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (tbl.rd_req && t_req < 0) t_req = i;
            if (sw_rd_ack && t_ack < 0) begin t_ack = i; rip = sw_rd_ip; te = timeout_err; end
        end
        rd_en = 1'b1;
        total++;
        if (t_ack - t_req !== 64 || t_req < 0) begin bad++; $display("FAIL to_rd_delay: got req=%0d ack=%0d want gap 64", t_req, t_ack); end
        total++;
        if (rip !== 32'h0) begin bad++; $display("FAIL to_rd_ip: got %h want 00000000", rip); end
        total++;
        if (te !== 1'b1) begin bad++; $display("FAIL to_err_set: got %b want 1", te); end
        total++;
        if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_err_sticky: got %b want 1", timeout_err); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        total++;
        if (timeout_err !== 1'b0) begin bad++; $display("FAIL to_err_clr: got %b want 0", timeout_err); end
    endtask

    task automatic test_ack_at_expiry(input int dly, input logic want_err);
        int t_req, t_ack;
        wr_dly = dly;
        sw_wr_req = 1'b1;
        sw_wr_addr = 4'd1;
        sw_wr_ip = 32'h0B0B_0B00 | 32'(dly);
        @(negedge clk);
        sw_wr_req = 1'b0;
        t_req = -1; t_ack = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tbl.wr_req && t_req < 0) t_req = i;
            if (sw_wr_ack && t_ack < 0) t_ack = i;
        end
        total++;
        if (t_ack - t_req !== 64 || t_req < 0) begin bad++; $display("FAIL expiry_delay_%0d: got req=%0d ack=%0d want gap 64", dly, t_req, t_ack); end
        total++;
        if (timeout_err !== want_err) begin bad++; $display("FAIL expiry_err_%0d: got %b want %b", dly, timeout_err, want_err); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic test_bulk_clear();
        int n, done, t_done, t_sw, nwack;
        logic aok, busy_mid;
        wr_dly = 0;
        clear_start = 1'b1;
        @(negedge clk);
        clear_start = 1'b0;
        n = 0; done = 0; t_done = -1; t_sw = -1; nwack = 0; aok = 1'b1; busy_mid = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            sw_wr_req = (i == 2);
            sw_wr_addr = 4'd2;
            sw_wr_ip = 32'h1111_1111;
            if (tbl.wr_req) begin
                if (n < 16 && (tbl.wr_addr !== 4'(n) || tbl.wr_ip !== 32'h0)) aok = 1'b0;
                if (n == 16 && tbl.wr_addr === 4'd2 && tbl.wr_ip === 32'h1111_1111) t_sw = i;
                n++;
            end
            if (clear_done) begin done++; t_done = i; end
            if (i == 10) busy_mid = clear_busy;
            nwack += int'(sw_wr_ack);
        end
        total++;
        if (n !== 17) begin bad++; $display("FAIL clr_wr_count: got %0d want 17", n); end
        total++;
        if (aok !== 1'b1) begin bad++; $display("FAIL clr_addr_seq: got out-of-order or nonzero ip want 0..15 ip 0"); end
        total++;
        if (done !== 1) begin bad++; $display("FAIL clr_done_count: got %0d want 1", done); end
        total++;
        if (t_sw <= t_done || t_done < 0) begin bad++; $display("FAIL clr_sw_after_done: got sw=%0d done=%0d want sw>done", t_sw, t_done); end
        total++;
        if ({busy_mid, clear_busy} !== 2'b10) begin bad++; $display("FAIL clr_busy: got %b want 10", {busy_mid, clear_busy}); end
        total++;
        if ({mem[15], mem[2], 32'(nwack)} !== {32'h0, 32'h1111_1111, 32'd1}) begin
            bad++;
            $display("FAIL clr_mem: got m15=%h m2=%h wack=%0d want 0/11111111/1", mem[15], mem[2], nwack);
        end
    endtask

    task automatic test_reset_mid_clear();
        logic found;
        int n_after, first_addr, done;
        wr_dly = 0;
        clear_start = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            clear_start = 1'b0;
            if (tbl.wr_req && tbl.wr_addr === 4'd9) found = 1'b1;
        end
        total++;
        if (found !== 1'b1) begin bad++; $display("FAIL rst_reach_entry9: got %b want 1", found); end
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({clear_busy, clear_done, tbl.wr_req, tbl.wr_addr, sw_wr_ack, sw_rd_ack} !== 9'b0) begin
            bad++;
            $display("FAIL rst_mid_outputs: got %b want 0", {clear_busy, clear_done, tbl.wr_req, tbl.wr_addr, sw_wr_ack, sw_rd_ack});
        end
        reset = 1'b0;
        n_after = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_after += int'(tbl.wr_req) + int'(clear_done) + int'(clear_busy);
        end
        total++;
        if (n_after !== 0) begin bad++; $display("FAIL rst_idle_after: got %0d want 0", n_after); end
        clear_start = 1'b1;
        first_addr = -1;
        done = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            clear_start = 1'b0;
            if (tbl.wr_req && first_addr < 0) first_addr = int'(tbl.wr_addr);
            done += int'(clear_done);
        end
        total++;
        if (first_addr !== 0) begin bad++; $display("FAIL rst_restart_addr: got %0d want 0", first_addr); end
        total++;
        if (done !== 1) begin bad++; $display("FAIL rst_restart_done: got %0d want 1", done); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_latency();
        test_write_read();
        test_same_cycle();
        test_dup_read();
        test_timeout();
        test_ack_at_expiry(62, 1'b0);
        test_ack_at_expiry(63, 1'b1);
        test_bulk_clear();
        test_reset_mid_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dest_ip_filter_table_ctrl.md
Name: dest_ip_filter_table_ctrl

Overview:
- Sequencer and arbiter for the register-side read/write port of the destination-IP filter CAM table.
- Shares that single port between the software register interface and an internal bulk-clear engine.
- The bulk-clear engine walks all LUT_DEPTH entries and writes IP 0 to each.
- Issues one table operation at a time, waits for its ack, and protects against a missing ack with a timeout.

Parameters:
- LUT_DEPTH, 16, number of table entries.
- LUT_DEPTH_BITS, log2(LUT_DEPTH), entry address width.
- ACK_TIMEOUT, 64, cycles to wait for a table ack before the operation is aborted.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- sw_rd_req  in  1  single-cycle read request pulse
- sw_rd_addr  in  LUT_DEPTH_BITS  read address, sampled with sw_rd_req
- sw_rd_ip  out  32  read result, valid while sw_rd_ack is high
- sw_rd_ack  out  1  single-cycle read completion pulse
- sw_wr_req  in  1  single-cycle write request pulse
- sw_wr_addr  in  LUT_DEPTH_BITS  write address, sampled with sw_wr_req
- sw_wr_ip  in  32  write IP, sampled with sw_wr_req
- sw_wr_ack  out  1  single-cycle write completion pulse
- clear_start  in  1  pulse that starts the bulk clear
- clear_busy  out  1  high while the clear is in progress
- clear_done  out  1  single-cycle pulse when the clear finishes
- timeout_err  out  1  sticky flag: a table ack timed out
- err_clr  in  1  clears timeout_err
- tbl_rd_req  out  1  read request pulse to the table
- tbl_rd_addr  out  LUT_DEPTH_BITS  table read address
- tbl_rd_ip  in  32  table read data
- tbl_rd_ack  in  1  table read ack
- tbl_wr_req  out  1  write request pulse to the table
- tbl_wr_addr  out  LUT_DEPTH_BITS  table write address
- tbl_wr_ip  out  32  table write IP
- tbl_wr_ack  in  1  table write ack

Behaviour:
- Reset is synchronous and active-high on clk.
- On reset, every output is 0, the FSM goes to IDLE, and all pending flags, the clear counter and the timeout counter are cleared.
- Reset mid-operation abandons that operation; no ack is returned for it.
- Request capture:
  - sw_rd_req and sw_wr_req each set a pending flag and latch their address/data.
  - A request pulse arriving while the same type is already pending is ignored; the latched values are kept.
  - A read and a write arriving in the same cycle are both captured.
- clear_start sets clear_pending; it is ignored while clear_busy or clear_pending is already set.
- FSM states: IDLE, RD_WAIT, WR_WAIT, CLR_ISSUE, CLR_WAIT, CLR_DONE.
- IDLE priority: clear_pending > write pending > read pending.
  - Clear selected: load entry counter with 0, set clear_busy, go to CLR_ISSUE.
  - Write selected: pulse tbl_wr_req for 1 cycle with the latched address/IP, go to WR_WAIT.
  - Read selected: pulse tbl_rd_req for 1 cycle with the latched address, go to RD_WAIT.
- Software requests stay pending for the whole clear, so a clear is never interleaved with software writes.
- RD_WAIT:
  - On tbl_rd_ack: register tbl_rd_ip into sw_rd_ip and pulse sw_rd_ack on the next cycle.
  - Clear the read pending flag and return to IDLE.
- WR_WAIT: on tbl_wr_ack, pulse sw_wr_ack on the next cycle, clear the write pending flag, return to IDLE.
- CLR_ISSUE: pulse tbl_wr_req with addr = counter and IP = 0, go to CLR_WAIT.
- CLR_WAIT: on tbl_wr_ack:
  - If counter == LUT_DEPTH-1, go to CLR_DONE.
  - Otherwise increment the counter and go to CLR_ISSUE.
  - The counter never wraps.
- CLR_DONE: pulse clear_done, drop clear_busy, return to IDLE.
- Timeout:
  - The timeout counter resets on every tbl_*_req and increments in every WAIT state.
  - Reaching ACK_TIMEOUT sets timeout_err and completes the operation as if it had been acked.
  - A timed-out read returns sw_rd_ip = 0.
  - A timed-out clear entry moves on to the next entry.
  - If the ack and the expiry land in the same cycle, the ack wins and no error is raised.
- err_clr clears timeout_err; if err_clr and a new timeout occur in the same cycle, the flag is set.
- tbl_rd_ack or tbl_wr_ack arriving outside its matching WAIT state is ignored.
- Latency with an immediate table ack:
  - Capture at cycle 0, tbl request at cycle 1, ack at cycle 2, sw ack at cycle 3.
  - Minimum software round trip is 3 cycles.
- Only one table operation is ever outstanding.

Decomposition:
- Shared package holds:
  - the FSM state encoding,
  - CLEAR_IP = 32'h0,
  - the log2 function.
- One natural sub-module, op_timeout_counter:
  - inputs: restart and run;
  - output: expired;
  - parameter: ACK_TIMEOUT.

Test Plan:
- Write then read: write addr 3 IP 0x0A000001, table acks after 2 cycles -> sw_wr_ack, then a read of addr 3 returns sw_rd_ip = 0x0A000001 with a single sw_rd_ack.
- Read and write in the same cycle: addr 5 read, addr 7 write -> tbl_wr_req is issued first, tbl_rd_req only after the write ack, and both sw acks arrive exactly once.
- Bulk clear, LUT_DEPTH = 16: clear_start -> 16 tbl_wr_req pulses with addresses 0..15 in order, all IP 0, and clear_done pulses once; a sw_wr_req issued mid-clear is served only after clear_done.
- Table never acks a read: sw_rd_ack comes 64 cycles after tbl_rd_req with sw_rd_ip = 0 and timeout_err = 1; err_clr then returns timeout_err to 0.
- Reset during CLR_WAIT at entry 9: all outputs go to 0 and the FSM returns to IDLE; a later clear_start restarts the clear from address 0.
- Duplicate sw_rd_req while a read is pending: only one tbl_rd_req and one sw_rd_ack occur, both for the original address.
